// File: rtl/my_float_pkg.sv
// my_float_pkg: binary32 field helpers, constants and input canonicalisation
package my_float_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction
    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[30:MAN_W];
    endfunction
    function automatic logic [MAN_W-1:0] f_man(input logic [31:0] x);
        return x[MAN_W-1:0];
    endfunction
    // denormals flush to signed zero, every NaN collapses to the one quiet NaN
    function automatic logic [31:0] canon(input logic [31:0] x);
        return (f_exp(x) == '0) ? {f_sign(x), 31'b0}
             : (f_exp(x) == '1 && f_man(x) != '0) ? QNAN : x;
    endfunction
endpackage

// File: rtl/my_float_add.sv
// my_float_add: combinational binary32 adder, flush-to-zero, round-to-nearest-even
module my_float_add import my_float_pkg::*; (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] ca, cb, big;
    logic [30:0] sml;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, sub;
    logic [7:0]  d;
    logic [4:0]  dc, lz;
    logic [53:0] shifted;
    logic [26:0] mb, ms, n;
    logic [27:0] s;
    logic [9:0]  e, ef;
    logic [24:0] r;
    logic [22:0] frac;
    always_comb begin
        ca = canon(a);
        cb = canon(b);
        a_nan = f_exp(ca) == 8'hFF && f_man(ca) != '0;
        b_nan = f_exp(cb) == 8'hFF && f_man(cb) != '0;
        a_inf = f_exp(ca) == 8'hFF && f_man(ca) == '0;
        b_inf = f_exp(cb) == 8'hFF && f_man(cb) == '0;
        a_zero = f_exp(ca) == '0;
        b_zero = f_exp(cb) == '0;
        swap = ca[30:0] < cb[30:0];
        big = swap ? cb : ca;
        sml = swap ? ca[30:0] : cb[30:0];
        sub = f_sign(ca) ^ f_sign(cb);
        d = f_exp(big) - sml[30:23];
        dc = (d > 8'd27) ? 5'd27 : d[4:0];
        // three extra bits below the mantissa: guard, round, sticky
        mb = {1'b1, f_man(big), 3'b0};
        shifted = {1'b1, sml[22:0], 3'b0, 27'b0} >> dc;
        ms = {shifted[53:28], shifted[27] | (|shifted[26:0])};
        s = sub ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};
        lz = 5'd0;
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        n = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << lz;
        // exponent kept in 10 bits so bit 9 flags underflow below zero
        e = s[27] ? {2'b0, f_exp(big)} + 10'd1 : {2'b0, f_exp(big)} - {5'b0, lz};
        r = {1'b0, n[26:3]} + {24'b0, n[2] & (n[3] | n[1] | n[0])};
        ef = e + {9'b0, r[24]};
        frac = r[24] ? r[23:1] : r[22:0];
        y = (a_nan || b_nan || (a_inf && b_inf && sub)) ? QNAN
          : a_inf ? ca
          : b_inf ? cb
          : (a_zero && b_zero) ? {ca[31] & cb[31], 31'b0}
          : a_zero ? cb
          : b_zero ? ca
          : (sub && ca[30:0] == cb[30:0]) ? 32'b0
          : (ef[9] || ef == '0) ? {big[31], 31'b0}
          : (ef >= 10'd255) ? {big[31], 8'hFF, 23'b0}
          : {big[31], ef[7:0], frac};
    end
endmodule

// File: rtl/my_float_accum.sv
// my_float_accum: streaming binary32 window accumulator with start delay
module my_float_accum import my_float_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int DELAY_W  = 32,
    parameter int STRIDE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                running,
    input  logic [STRIDE_W-1:0] strideMinusOne,
    input  logic [DELAY_W-1:0]  delay0,
    input  logic [DATA_W-1:0]   in0,
    output logic [DATA_W-1:0]   out0
);
    logic [DATA_W-1:0]   acc, sum;
    logic [DELAY_W-1:0]  delay_cnt;
    logic [STRIDE_W-1:0] stride_cnt, stride_max;
    my_float_add u_add (.a(acc), .b(in0), .y(sum));
    assign out0 = acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            delay_cnt  <= '0;
            stride_cnt <= '0;
            stride_max <= '0;
        end else if (run) begin
            delay_cnt  <= delay0;
            stride_max <= strideMinusOne;
            stride_cnt <= '0;
        end else if (running) begin
            if (delay_cnt != '0) begin
                delay_cnt <= delay_cnt - 1'b1;
            end else begin
                acc        <= (stride_cnt == '0) ? canon(in0) : sum;
                stride_cnt <= (stride_cnt == stride_max) ? '0 : stride_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_my_float_accum.sv
// tb_my_float_accum: vector tables and corner sequences checked through a scoreboard
module tb_my_float_accum;
    logic clk = 1'b0, rst, run, running;
    logic [31:0] stride_m1, delay, in0, out0;
    int total = 0, bad = 0;
    typedef struct { logic [31:0] x; logic [31:0] e; } vec_t;
    typedef struct { logic [31:0] a; logic [31:0] ca; logic [31:0] b; logic [31:0] e; } add_t;
    typedef struct { logic [31:0] e; string nm; } sb_t;
    sb_t sb[$];
    vec_t tab[512];
    add_t adds[19];
    logic [31:0] win[5];

    always #5 clk = ~clk;

    my_float_accum dut (
        .clk(clk), .rst(rst), .run(run), .running(running),
        .strideMinusOne(stride_m1), .delay0(delay), .in0(in0), .out0(out0)
    );

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step(logic r, logic rn, logic [31:0] x, logic [31:0] e, string nm);
        sb_t t;
        run = r;
        running = rn;
        in0 = x;
        sb.push_back('{e, nm});
        @(posedge clk);
        #1;
        t = sb.pop_front();
        check(t.nm, out0, t.e);
    endtask

    task automatic arm(logic [31:0] d, logic [31:0] s, logic [31:0] hold);
        delay = d;
        stride_m1 = s;
        step(1'b1, 1'b0, 32'hDEADBEEF, hold, "run_hold");
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [7:0] ex;
            logic sg;
            ex = 8'(i);
            sg = (i >= 256);
            tab[i].x = {sg, ex, 22'b0, 1'b1};
            tab[i].e = (ex == 8'd0) ? {sg, 31'b0} : (ex == 8'hFF) ? 32'h7FC00000 : tab[i].x;
        end
        adds = '{
            '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000},
            '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000},
            '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000},
            '{32'h7F800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
            '{32'h3F800000, 32'h3F800000, 32'h33800000, 32'h3F800000},
            '{32'h3F800000, 32'h3F800000, 32'h33800001, 32'h3F800001},
            '{32'h3F800001, 32'h3F800001, 32'h33800000, 32'h3F800002},
            '{32'h00800000, 32'h00800000, 32'h80800001, 32'h80000000},
            '{32'h40400000, 32'h40400000, 32'hC0000000, 32'h3F800000},
            '{32'h00000001, 32'h00000000, 32'h3F800000, 32'h3F800000},
            '{32'h7F800001, 32'h7FC00000, 32'h3F800000, 32'h7FC00000},
            '{32'h4B7FFFFF, 32'h4B7FFFFF, 32'h3F800000, 32'h4B800000},
            '{32'h3F800000, 32'h3F800000, 32'hB3800000, 32'h3F7FFFFF},
            '{32'h3F800000, 32'h3F800000, 32'hB3000000, 32'h3F800000},
            '{32'hC0000000, 32'hC0000000, 32'h3F800000, 32'hBF800000},
            '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
            '{32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000},
            '{32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h7F800000}
        };
        win = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};

        rst = 1'b1; run = 1'b0; running = 1'b0; in0 = '0; delay = '0; stride_m1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", out0, 32'h0);
        rst = 1'b0;

        arm(32'd0, 32'd0, 32'h0);
        repeat (6) step(1'b0, 1'b1, 32'hFF800000, 32'hFF800000, "neg_inf");

        arm(32'd0, 32'd0, 32'hFF800000);
        for (int i = 0; i < 512; i++) step(1'b0, 1'b1, tab[i].x, tab[i].e, "canon");
        step(1'b0, 1'b0, 32'h3F800000, tab[511].e, "idle_hold");

        arm(32'd0, 32'd3, tab[511].e);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h3F800000, win[i], "window4");

        arm(32'd2, 32'd0, 32'h3F800000);
        step(1'b0, 1'b1, 32'h40000000, 32'h3F800000, "delay_skip0");
        step(1'b0, 1'b1, 32'h40000000, 32'h3F800000, "delay_skip1");
        step(1'b0, 1'b1, 32'h40000000, 32'h40000000, "delay_done");

        delay = 32'd0;
        stride_m1 = 32'd1;
        step(1'b1, 1'b1, 32'h40400000, 32'h40000000, "run_priority");
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 1'b1, adds[i].a, adds[i].ca, "add_first");
            step(1'b0, 1'b1, adds[i].b, adds[i].e, "add_sum");
        end

        arm('1, '1, 32'h7F800000);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, i[0] ? 32'h3F800000 : 32'hC0000000, 32'h7F800000, "long_delay");

        rst = 1'b1;
        step(1'b0, 1'b1, 32'h3F800000, 32'h0, "mid_reset");
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h3F800000, 32'h0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
